// File: rtl/upsample_line_buffer.sv
// One-row pixel store for the 2x upsampler: registered write, combinational read.
// The top only writes while accepting in PASS and only reads in REPLAY.
module upsample_line_buffer #(
  parameter int DATA_WIDHT = 32,
  parameter int IMG_WIDHT  = 22,
  localparam int AW = (IMG_WIDHT > 1) ? $clog2(IMG_WIDHT) : 1
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDHT-1:0] wr_data,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDHT-1:0] rd_data
);

  logic [DATA_WIDHT-1:0] mem [IMG_WIDHT];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/upsample_nearest_2x_stream.sv
// Streaming 2x nearest-neighbour upsampler: each pixel is emitted twice on the
// way in (PASS), then the whole row is replayed once from the line buffer (REPLAY).
module upsample_nearest_2x_stream #(
  parameter int DATA_WIDHT = 32,
  parameter int IMG_WIDHT  = 22,
  parameter int IMG_HEIGHT = 22
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDHT-1:0] Data_In,
  input  logic                  Valid_In,
  output logic                  Ready_Out,
  output logic [DATA_WIDHT-1:0] Data_Out,
  output logic                  Valid_Out
);

  localparam int CW = (IMG_WIDHT  > 1) ? $clog2(IMG_WIDHT)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  typedef enum logic {PASS = 1'b0, REPLAY = 1'b1} state_t;

  state_t                state;
  logic                  phase;
  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  logic [DATA_WIDHT-1:0] rd_data;
  logic                  accept;
  logic                  last_col;
  logic                  last_row;

  assign Ready_Out = (state == PASS) && !phase;
  assign accept    = Valid_In && Ready_Out;
  assign last_col  = (col == CW'(IMG_WIDHT - 1));
  assign last_row  = (row == RW'(IMG_HEIGHT - 1));

  upsample_line_buffer #(
    .DATA_WIDHT(DATA_WIDHT),
    .IMG_WIDHT (IMG_WIDHT)
  ) u_linebuf (
    .clk    (clk),
    .wr_en  (accept),
    .wr_addr(col),
    .wr_data(Data_In),
    .rd_addr(col),
    .rd_data(rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= PASS;
      phase     <= 1'b0;
      col       <= '0;
      row       <= '0;
      Data_Out  <= '0;
      Valid_Out <= 1'b0;
    end else begin
      case (state)
        PASS: begin
          if (!phase) begin
            if (Valid_In) begin
              Data_Out  <= Data_In;
              Valid_Out <= 1'b1;
              phase     <= 1'b1;
            end else begin
              Valid_Out <= 1'b0;
            end
          end else begin
            // repeat cycle: Data_Out holds the pixel for its second copy
            Valid_Out <= 1'b1;
            phase     <= 1'b0;
            if (last_col) begin
              col   <= '0;
              state <= REPLAY;
            end else begin
              col <= col + CW'(1);
            end
          end
        end
        REPLAY: begin
          Data_Out  <= rd_data;
          Valid_Out <= 1'b1;
          phase     <= ~phase;
          if (phase) begin
            if (last_col) begin
              col   <= '0;
              state <= PASS;
              row   <= last_row ? '0 : row + RW'(1);
            end else begin
              col <= col + CW'(1);
            end
          end
        end
        default: state <= PASS;
      endcase
    end
  end

endmodule
